// File: rtl/alu_program_sequencer.sv
// Program-buffer sequencer for the 8-bit ALU/register-file datapath: issues each stored
// instruction, holds it for a fixed settle time, captures the result and sticky flags.
module alu_program_sequencer #(
   parameter int INSTR_WIDTH  = 26,
   parameter int DEPTH        = 16,
   parameter int ADDR_WIDTH   = 4,
   parameter int RESULT_WIDTH = 16,
   parameter int HOLD_CYCLES  = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load_en,
   input  logic [ADDR_WIDTH-1:0]   load_addr,
   input  logic [INSTR_WIDTH-1:0]  load_instr,
   input  logic [ADDR_WIDTH:0]     prog_len,
   input  logic                    start,
   input  logic                    abort,
   output logic [INSTR_WIDTH-1:0]  instruction,
   input  logic [RESULT_WIDTH-1:0] alu_out,
   input  logic                    alu_overflow,
   input  logic                    alu_c_out,
   output logic                    issue_valid,
   output logic [ADDR_WIDTH-1:0]   pc,
   output logic                    busy,
   output logic                    done,
   output logic [RESULT_WIDTH-1:0] result,
   output logic                    overflow_seen,
   output logic                    c_out_seen
);

   localparam int                LEN_W     = ADDR_WIDTH + 1;
   localparam logic [LEN_W-1:0]  DEPTH_L   = LEN_W'(DEPTH);
   localparam logic [3:0]        HOLD_LOAD = 4'(HOLD_CYCLES - 1);
   localparam bit                HAS_WAIT  = (HOLD_CYCLES > 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [3:0]              hold_q, hold_d;
   logic [INSTR_WIDTH-1:0]  instruction_q, instruction_d;
   logic                    issue_valid_q, issue_valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [RESULT_WIDTH-1:0] result_q, result_d;
   logic                    overflow_seen_q, overflow_seen_d;
   logic                    c_out_seen_q, c_out_seen_d;
   logic [INSTR_WIDTH-1:0]  prog_mem_q [DEPTH];
   logic                    wr_en_s;
   logic                    active_s;
   logic [INSTR_WIDTH-1:0]  instr_src_s;

   // Next-state, program counter, hold counter and capture logic.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      len_d           = len_q;
      hold_d          = hold_q;
      result_d        = result_q;
      overflow_seen_d = overflow_seen_q;
      c_out_seen_d    = c_out_seen_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d           = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
               overflow_seen_d = 1'b0;
               c_out_seen_d    = 1'b0;
               if (len_d == {LEN_W{1'b0}}) begin
                  state_d = S_DONE;
               end else begin
                  pc_d    = {ADDR_WIDTH{1'b0}};
                  state_d = S_ISSUE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            hold_d = HOLD_LOAD;
            if (abort) begin
               state_d = S_IDLE;
            end else if (HAS_WAIT) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_WAIT: begin
            hold_d = hold_q - 4'd1;
            if (abort) begin
               state_d = S_IDLE;
            end else if (hold_q == 4'd1) begin
               state_d = S_CAPTURE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_CAPTURE: begin
            // The capture lands even when abort arrives in the same cycle.
            result_d        = alu_out;
            overflow_seen_d = overflow_seen_q | alu_overflow;
            c_out_seen_d    = c_out_seen_q | alu_c_out;
            if (abort) begin
               state_d = S_IDLE;
            end else if ({1'b0, pc_q} == (len_q - LEN_W'(1))) begin
               state_d = S_DONE;
            end else begin
               pc_d    = pc_q + ADDR_WIDTH'(1);
               state_d = S_ISSUE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output next-values follow the next state; a same-cycle buffer write is forwarded.
   always_comb begin
      wr_en_s     = load_en && (state_q == S_IDLE);
      active_s    = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CAPTURE);
      if (wr_en_s && (load_addr == pc_d)) begin
         instr_src_s = load_instr;
      end else begin
         instr_src_s = prog_mem_q[pc_d];
      end
      instruction_d = active_s ? instr_src_s : {INSTR_WIDTH{1'b0}};
      issue_valid_d = (state_d == S_ISSUE);
      busy_d        = active_s;
      done_d        = (state_d == S_DONE);
   end

   // Control and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         pc_q            <= {ADDR_WIDTH{1'b0}};
         len_q           <= {LEN_W{1'b0}};
         hold_q          <= 4'd0;
         instruction_q   <= {INSTR_WIDTH{1'b0}};
         issue_valid_q   <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         result_q        <= {RESULT_WIDTH{1'b0}};
         overflow_seen_q <= 1'b0;
         c_out_seen_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         len_q           <= len_d;
         hold_q          <= hold_d;
         instruction_q   <= instruction_d;
         issue_valid_q   <= issue_valid_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         result_q        <= result_d;
         overflow_seen_q <= overflow_seen_d;
         c_out_seen_q    <= c_out_seen_d;
      end
   end

   // Program buffer, intentionally left unreset.
   always_ff @(posedge clock) begin
      if (wr_en_s) begin
         prog_mem_q[load_addr] <= load_instr;
      end
   end

   assign instruction   = instruction_q;
   assign issue_valid   = issue_valid_q;
   assign pc            = pc_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign result        = result_q;
   assign overflow_seen = overflow_seen_q;
   assign c_out_seen    = c_out_seen_q;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Directed self-checking bench for alu_program_sequencer with a combinational ALU stub.
module tb_alu_program_sequencer;

   localparam logic [25:0] W_A = 26'h1A0_0001;
   localparam logic [25:0] W_B = 26'h1B0_0002;
   localparam logic [25:0] W_C = 26'h1C0_0003;
   localparam logic [25:0] W_D = 26'h1D0_0004;
   localparam logic [25:0] W_X = 26'h3FF_FFFF;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [25:0] load_instr;
   logic [4:0]  prog_len;
   logic        start;
   logic        abort;
   logic [25:0] instruction;
   logic [15:0] alu_out;
   logic        alu_overflow;
   logic        alu_c_out;
   logic        issue_valid;
   logic [3:0]  pc;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        overflow_seen;
   logic        c_out_seen;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   alu_program_sequencer dut (
      .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_instr(load_instr), .prog_len(prog_len), .start(start), .abort(abort),
      .instruction(instruction), .alu_out(alu_out), .alu_overflow(alu_overflow),
      .alu_c_out(alu_c_out), .issue_valid(issue_valid), .pc(pc), .busy(busy),
      .done(done), .result(result), .overflow_seen(overflow_seen), .c_out_seen(c_out_seen)
   );

   always #5 clock = ~clock;

   // ALU stub: known words give fixed results, B raises overflow, carry never set.
   always_comb begin
      alu_out      = instruction[15:0];
      alu_overflow = 1'b0;
      alu_c_out    = 1'b0;
      if (instruction == W_A) begin
         alu_out = 16'h0011;
      end else if (instruction == W_B) begin
         alu_out      = 16'h0022;
         alu_overflow = 1'b1;
      end else if (instruction == W_C) begin
         alu_out = 16'h0033;
      end else if (instruction == W_D) begin
         alu_out = 16'h0044;
      end
   end

   function automatic logic [25:0] mk(input int i);
      return 26'h200_0000 | (26'(i) << 8) | 26'(i);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_word(input logic [3:0] a, input logic [25:0] w);
      load_en    = 1'b1;
      load_addr  = a;
      load_instr = w;
      tick();
      load_en    = 1'b0;
   endtask

   task automatic load_abc();
      load_word(4'd0, W_A);
      load_word(4'd1, W_B);
      load_word(4'd2, W_C);
   endtask

   task automatic test_reset();
      reset = 1'b1; load_en = 1'b0; load_addr = 4'd0; load_instr = 26'd0;
      prog_len = 5'd0; start = 1'b0; abort = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk_cnt++;
      if (instruction !== 26'd0 || pc !== 4'd0 || issue_valid !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || result !== 16'd0 || overflow_seen !== 1'b0 || c_out_seen !== 1'b0)
         $display("FAIL reset_state: instr=%h pc=%0d iv=%b busy=%b done=%b result=%h ovf=%b cout=%b, required all zero",
                  instruction, pc, issue_valid, busy, done, result, overflow_seen, c_out_seen);
      else pass_cnt++;
      load_abc();
      prog_len = 5'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk_cnt++;
      if (pc !== 4'd1 || busy !== 1'b1 || result !== 16'h0011)
         $display("FAIL reset_prerun: pc=%0d busy=%b result=%h, required pc=1 busy=1 result=0011", pc, busy, result);
      else pass_cnt++;
      #1 reset = 1'b1;
      #1;
      chk_cnt++;
      if (instruction !== 26'd0 || busy !== 1'b0 || result !== 16'd0 || overflow_seen !== 1'b0 ||
          c_out_seen !== 1'b0 || issue_valid !== 1'b0 || pc !== 4'd0)
         $display("FAIL reset_midrun: instr=%h busy=%b result=%h ovf=%b cout=%b iv=%b pc=%0d, required all zero",
                  instruction, busy, result, overflow_seen, c_out_seen, issue_valid, pc);
      else pass_cnt++;
      #2 reset = 1'b0;
      tick();
      chk_cnt++;
      if (busy !== 1'b0 || instruction !== 26'd0 || done !== 1'b0)
         $display("FAIL reset_idle: busy=%b instr=%h done=%b, required 0 0 0", busy, instruction, done);
      else pass_cnt++;
   endtask

   task automatic test_normal_run();
      logic [25:0] seq [3];
      seq[0] = W_A; seq[1] = W_B; seq[2] = W_C;
      load_abc();
      prog_len = 5'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         chk_cnt++;
         if (busy !== 1'b1 || instruction !== seq[k/3] || issue_valid !== ((k % 3) == 0) ||
             pc !== 4'(k/3) || done !== 1'b0)
            $display("FAIL run_cycle%0d: busy=%b instr=%h iv=%b pc=%0d done=%b, required busy=1 instr=%h iv=%b pc=%0d done=0",
                     k, busy, instruction, issue_valid, pc, done, seq[k/3], ((k % 3) == 0), k/3);
         else pass_cnt++;
         tick();
      end
      chk_cnt++;
      if (done !== 1'b1 || busy !== 1'b0 || instruction !== 26'd0 || result !== 16'h0033)
         $display("FAIL run_done: done=%b busy=%b instr=%h result=%h, required 1 0 0 0033", done, busy, instruction, result);
      else pass_cnt++;
   endtask

   task automatic test_sticky_flags();
      int n;
      chk_cnt++;
      if (overflow_seen !== 1'b1 || c_out_seen !== 1'b0)
         $display("FAIL sticky_at_done: ovf=%b cout=%b, required 1 0", overflow_seen, c_out_seen);
      else pass_cnt++;
      prog_len = 5'd3; start = 1'b1;
      tick();
      chk_cnt++;
      if (busy !== 1'b0 || overflow_seen !== 1'b1)
         $display("FAIL start_in_done: busy=%b ovf=%b, required 0 1", busy, overflow_seen);
      else pass_cnt++;
      tick();
      start = 1'b0;
      chk_cnt++;
      if (busy !== 1'b1 || issue_valid !== 1'b1 || instruction !== W_A || overflow_seen !== 1'b0 || c_out_seen !== 1'b0)
         $display("FAIL sticky_clear: busy=%b iv=%b instr=%h ovf=%b cout=%b, required 1 1 %h 0 0",
                  busy, issue_valid, instruction, overflow_seen, c_out_seen, W_A);
      else pass_cnt++;
      n = 0;
      while (done !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk_cnt++;
      if (done !== 1'b1 || overflow_seen !== 1'b1 || c_out_seen !== 1'b0 || result !== 16'h0033)
         $display("FAIL sticky_rerun: done=%b ovf=%b cout=%b result=%h, required 1 1 0 0033", done, overflow_seen, c_out_seen, result);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_edge_lengths();
      int busy_cycles;
      int issues;
      int n;
      bit seq_ok;
      logic [25:0] w_last;
      prog_len = 5'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk_cnt++;
      if (done !== 1'b1 || busy !== 1'b0 || instruction !== 26'd0 || result !== 16'h0033)
         $display("FAIL len0_done: done=%b busy=%b instr=%h result=%h, required 1 0 0 0033", done, busy, instruction, result);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL len0_after: done=%b busy=%b, required 0 0", done, busy);
      else pass_cnt++;
      for (int i = 0; i < 16; i++) load_word(4'(i), mk(i));
      prog_len = 5'd20; start = 1'b1;
      tick();
      start = 1'b0;
      busy_cycles = 0; issues = 0; n = 0; seq_ok = 1'b1;
      while (busy === 1'b1 && n < 200) begin
         if (issue_valid === 1'b1) begin
            if (instruction !== mk(issues) || pc !== 4'(issues)) seq_ok = 1'b0;
            issues++;
         end
         busy_cycles++;
         n++;
         tick();
      end
      chk_cnt++;
      if (busy_cycles != 48)
         $display("FAIL len20_busy: busy_cycles=%0d, required 48", busy_cycles);
      else pass_cnt++;
      chk_cnt++;
      if (issues != 16 || !seq_ok)
         $display("FAIL len20_seq: issues=%0d seq_ok=%b, required 16 1", issues, seq_ok);
      else pass_cnt++;
      w_last = mk(15);
      chk_cnt++;
      if (done !== 1'b1 || pc !== 4'd15 || result !== w_last[15:0])
         $display("FAIL len20_done: done=%b pc=%0d result=%h, required 1 15 %h", done, pc, result, w_last[15:0]);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (pc !== 4'd15 || busy !== 1'b0)
         $display("FAIL len20_pc_hold: pc=%0d busy=%b, required 15 0", pc, busy);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      int done_seen;
      load_abc();
      prog_len = 5'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk_cnt++;
      if (pc !== 4'd1 || busy !== 1'b1 || issue_valid !== 1'b0)
         $display("FAIL abort_pre: pc=%0d busy=%b iv=%b, required 1 1 0", pc, busy, issue_valid);
      else pass_cnt++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_cnt++;
      if (busy !== 1'b0 || instruction !== 26'd0 || done !== 1'b0 || result !== 16'h0011 || overflow_seen !== 1'b0)
         $display("FAIL abort_idle: busy=%b instr=%h done=%b result=%h ovf=%b, required 0 0 0 0011 0",
                  busy, instruction, done, result, overflow_seen);
      else pass_cnt++;
      done_seen = 0;
      repeat (3) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      chk_cnt++;
      if (done_seen != 0)
         $display("FAIL abort_quiet: done/busy cycles=%0d, required 0", done_seen);
      else pass_cnt++;
   endtask

   task automatic test_ignored_inputs();
      logic [25:0] seq [3];
      int n;
      seq[0] = W_A; seq[1] = W_B; seq[2] = W_C;
      prog_len = 5'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         load_en = (k == 1);
         load_addr = 4'd1; load_instr = W_X;
         start = (k == 4);
         chk_cnt++;
         if (busy !== 1'b1 || instruction !== seq[k/3])
            $display("FAIL ignored_cycle%0d: busy=%b instr=%h, required 1 %h", k, busy, instruction, seq[k/3]);
         else pass_cnt++;
         tick();
      end
      load_en = 1'b0; start = 1'b0;
      chk_cnt++;
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL ignored_done: done=%b busy=%b, required 1 0", done, busy);
      else pass_cnt++;
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk_cnt++;
      if (instruction !== W_B || issue_valid !== 1'b1 || pc !== 4'd1)
         $display("FAIL rerun_buffer: instr=%h iv=%b pc=%0d, required %h 1 1", instruction, issue_valid, pc, W_B);
      else pass_cnt++;
      n = 0;
      while (done !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      tick();
      load_en = 1'b1; load_addr = 4'd0; load_instr = W_D;
      prog_len = 5'd1; start = 1'b1;
      tick();
      load_en = 1'b0; start = 1'b0;
      chk_cnt++;
      if (instruction !== W_D || issue_valid !== 1'b1 || busy !== 1'b1)
         $display("FAIL load_start_same: instr=%h iv=%b busy=%b, required %h 1 1", instruction, issue_valid, busy, W_D);
      else pass_cnt++;
      n = 0;
      while (done !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk_cnt++;
      if (done !== 1'b1 || result !== 16'h0044)
         $display("FAIL load_start_result: done=%b result=%h, required 1 0044", done, result);
      else pass_cnt++;
      tick();
   endtask

   initial begin
      test_reset();
      test_normal_run();
      test_sticky_flags();
      test_edge_lengths();
      test_abort();
      test_ignored_inputs();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
